// File: rtl/dsm_mod_ctrl_pkg.sv
// Shared state encoding, silence constant and width helper for the delta-sigma modulator
// controller.
package dsm_mod_ctrl_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StPrime = 2'd1,
    StRun   = 2'd2,
    StMute  = 2'd3
  } state_e;

  localparam logic [7:0] SilencePattern = 8'h69;

  // Ceiling log2 with a floor of one bit, for counter widths.
  function automatic int unsigned clog2(input int unsigned val);
    int unsigned res;
    res = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < val) res = i + 1;
    end
    return (res == 0) ? 1 : res;
  endfunction

endpackage

// File: rtl/dsm_bclk_gen.sv
// DSD bit clock generator: free-running MCLK divider, registered 50% duty BCK and a one-cycle
// bit tick on the last divider count.
module dsm_bclk_gen
  import dsm_mod_ctrl_pkg::*;
#(
  parameter int unsigned DIV_RATIO = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  output logic bck_o,
  output logic bit_tick_o
);

  localparam int unsigned DivW = clog2(DIV_RATIO);
  localparam logic [DivW-1:0] DivLast = DivW'(DIV_RATIO - 1);
  localparam logic [DivW-1:0] DivHalf = DivW'(DIV_RATIO / 2);

  logic [DivW-1:0] div_cnt_q, div_cnt_d;
  logic            bck_q;

  always_comb begin
    div_cnt_d = (div_cnt_q == DivLast) ? '0 : div_cnt_q + DivW'(1);
  end

  // BCK is registered from the next count so it lines up with div_cnt itself.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      div_cnt_q <= '0;
      bck_q     <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      bck_q     <= (div_cnt_d >= DivHalf);
    end
  end

  assign bck_o      = bck_q;
  assign bit_tick_o = (div_cnt_q == DivLast);

endmodule

// File: rtl/dsm_mod_ctrl.sv
// Sequencer for the 1-bit delta-sigma modulator: PCM hold/handshake, step strobes, DSD output.
// Define DSM_CTRL_SILENCE_PATTERN_EN to emit 8'h69 as silence instead of alternating 1,0.
module dsm_mod_ctrl
  import dsm_mod_ctrl_pkg::*;
#(
  parameter int unsigned PCM_Bit_Length = 32,
  parameter int unsigned DIV_RATIO      = 4,
  parameter int unsigned OSR            = 64,
  parameter int unsigned UNDERRUN_LIMIT = 4
) (
  input  logic                      MCLK_I,
  input  logic                      NRST_I,
  input  logic                      EN_I,
  input  logic [PCM_Bit_Length-1:0] PCM_DATA_I,
  input  logic                      PCM_VALID_I,
  output logic                      PCM_READY_O,
  output logic [PCM_Bit_Length-1:0] DSM_DATA_O,
  output logic                      DSM_EN_O,
  output logic                      DSM_CLR_O,
  input  logic                      QUANT_DATA_I,
  output logic                      DSD_DATA_O,
  output logic                      DSD_BCK_O,
  output logic                      UNDERRUN_O,
  output logic [1:0]                STATE_O
);

  localparam int unsigned OsrW = clog2(OSR);
  localparam int unsigned UnrW = clog2(UNDERRUN_LIMIT + 1);
  localparam logic [OsrW-1:0] OsrLast = OsrW'(OSR - 1);
  localparam logic [UnrW-1:0] UnrLast = UnrW'(UNDERRUN_LIMIT - 1);

  state_e                    state_q, state_d;
  logic                      bit_tick;
  logic                      nxt_full_q;
  logic [PCM_Bit_Length-1:0] hold_q, dsm_data_q;
  logic [OsrW-1:0]           osr_cnt_q;
  logic [UnrW-1:0]           unr_cnt_q;
  logic                      underrun_q, dsd_q, sil_bit;
  logic                      pcm_ready, handshake, dsm_en, consume, underrun_ev;

  dsm_bclk_gen #(
    .DIV_RATIO(DIV_RATIO)
  ) u_bclk_gen (
    .clk_i     (MCLK_I),
    .rst_ni    (NRST_I),
    .bck_o     (DSD_BCK_O),
    .bit_tick_o(bit_tick)
  );

  always_comb begin
    pcm_ready   = (state_q != StIdle) && !nxt_full_q;
    handshake   = PCM_VALID_I && pcm_ready;
    dsm_en      = bit_tick && (state_q == StRun);
    consume     = dsm_en && (osr_cnt_q == OsrLast);
    underrun_ev = consume && !nxt_full_q && !handshake;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (EN_I) state_d = StPrime;
      StPrime: if (bit_tick && nxt_full_q) state_d = StRun;
      StRun:   if (underrun_ev && (unr_cnt_q == UnrLast)) state_d = StMute;
      StMute:  state_d = StPrime;
      default: state_d = StIdle;
    endcase
    // Dropping the run request wins over every other transition.
    if (!EN_I) state_d = StIdle;
  end

  always_ff @(posedge MCLK_I or negedge NRST_I) begin
    if (!NRST_I) begin
      state_q    <= StIdle;
      nxt_full_q <= 1'b0;
      hold_q     <= '0;
      dsm_data_q <= '0;
      osr_cnt_q  <= '0;
      unr_cnt_q  <= '0;
      underrun_q <= 1'b0;
      dsd_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      if (handshake) begin
        hold_q     <= PCM_DATA_I;
        nxt_full_q <= 1'b1;
      end
      if (dsm_en) osr_cnt_q <= consume ? '0 : osr_cnt_q + OsrW'(1);
      if (consume) begin
        if (nxt_full_q) begin
          dsm_data_q <= hold_q;
          nxt_full_q <= 1'b0;
          unr_cnt_q  <= '0;
        end else if (handshake) begin
          // Sample arrived just in time: feed it straight through, hold stays empty.
          dsm_data_q <= PCM_DATA_I;
          nxt_full_q <= 1'b0;
          unr_cnt_q  <= '0;
        end else begin
          dsm_data_q <= '0;
          underrun_q <= 1'b1;
          unr_cnt_q  <= unr_cnt_q + UnrW'(1);
        end
      end
      if ((state_q == StPrime) && (state_d == StRun)) begin
        dsm_data_q <= hold_q;
        nxt_full_q <= 1'b0;
        osr_cnt_q  <= '0;
      end
      if (state_q == StMute) begin
        dsm_data_q <= '0;
        unr_cnt_q  <= '0;
      end
      if (state_d == StIdle) begin
        nxt_full_q <= 1'b0;
        underrun_q <= 1'b0;
        unr_cnt_q  <= '0;
      end
      if (bit_tick) dsd_q <= (state_q == StRun) ? QUANT_DATA_I : sil_bit;
    end
  end

`ifdef DSM_CTRL_SILENCE_PATTERN_EN
  logic [2:0] sil_ptr_q;

  // Pointer parks at the MSB while running so each silence burst starts from bit 7.
  always_ff @(posedge MCLK_I or negedge NRST_I) begin
    if (!NRST_I) begin
      sil_ptr_q <= 3'd7;
    end else if (state_q == StRun) begin
      sil_ptr_q <= 3'd7;
    end else if (bit_tick) begin
      sil_ptr_q <= sil_ptr_q - 3'd1;
    end
  end

  assign sil_bit = SilencePattern[sil_ptr_q];
`else
  logic sil_q;

  always_ff @(posedge MCLK_I or negedge NRST_I) begin
    if (!NRST_I) begin
      sil_q <= 1'b1;
    end else if (state_q == StRun) begin
      sil_q <= 1'b1;
    end else if (bit_tick) begin
      sil_q <= ~sil_q;
    end
  end

  assign sil_bit = sil_q;
`endif

  assign PCM_READY_O = pcm_ready;
  assign DSM_DATA_O  = dsm_data_q;
  assign DSM_EN_O    = dsm_en;
  assign DSM_CLR_O   = (state_q != StRun);
  assign DSD_DATA_O  = dsd_q;
  assign UNDERRUN_O  = underrun_q;
  assign STATE_O     = state_q;

endmodule

// File: tb/tb_dsm_mod_ctrl.sv
// Scoreboard bench for dsm_mod_ctrl: accepted samples are queued and checked on every step
// strobe; quantizer bits are checked on the DSD output one MCLK after each strobe.
module tb_dsm_mod_ctrl;

  localparam int W   = 32;
  localparam int DIV = 4;
  localparam int OSR = 8;
  localparam int LIM = 2;

  logic         MCLK_I = 1'b0;
  logic         NRST_I, EN_I, PCM_VALID_I, QUANT_DATA_I;
  logic [W-1:0] PCM_DATA_I, DSM_DATA_O;
  logic         PCM_READY_O, DSM_EN_O, DSM_CLR_O, DSD_DATA_O, DSD_BCK_O, UNDERRUN_O;
  logic [1:0]   STATE_O;

  int           checks = 0;
  int           failures = 0;
  logic [W-1:0] exp_data_q[$];
  int           pulse_cnt = 0, en_total = 0, cyc = 0, last_pulse = 0;
  bit           mon_en = 1'b0, dsd_due = 1'b0, en_seen = 1'b0;
  logic         exp_bit;
  logic [3:0]   qbits = 4'b1011;
  int           qi = 0;
  logic [7:0]   sil_exp;

  dsm_mod_ctrl #(
    .PCM_Bit_Length(W),
    .DIV_RATIO     (DIV),
    .OSR           (OSR),
    .UNDERRUN_LIMIT(LIM)
  ) dut (
    .MCLK_I      (MCLK_I),
    .NRST_I      (NRST_I),
    .EN_I        (EN_I),
    .PCM_DATA_I  (PCM_DATA_I),
    .PCM_VALID_I (PCM_VALID_I),
    .PCM_READY_O (PCM_READY_O),
    .DSM_DATA_O  (DSM_DATA_O),
    .DSM_EN_O    (DSM_EN_O),
    .DSM_CLR_O   (DSM_CLR_O),
    .QUANT_DATA_I(QUANT_DATA_I),
    .DSD_DATA_O  (DSD_DATA_O),
    .DSD_BCK_O   (DSD_BCK_O),
    .UNDERRUN_O  (UNDERRUN_O),
    .STATE_O     (STATE_O)
  );

  initial forever #5 MCLK_I = ~MCLK_I;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick_n(input int n);
    repeat (n) @(posedge MCLK_I);
    #1;
  endtask

  task automatic send(input logic [W-1:0] d);
    int n;
    n = 0;
    while (!PCM_READY_O && n < 500) begin
      tick_n(1);
      n++;
    end
    check_eq("ready_wait", 32'(n < 500), 1);
    PCM_DATA_I  = d;
    PCM_VALID_I = 1'b1;
    exp_data_q.push_back(d);
    tick_n(1);
    PCM_VALID_I = 1'b0;
  endtask

  // Quantizer stimulus: step through 1,1,0,1 once per modulator strobe.
  initial begin
    QUANT_DATA_I = qbits[0];
    forever begin
      @(posedge MCLK_I);
      #1;
      if (en_seen) begin
        qi = (qi + 1) % 4;
        QUANT_DATA_I = qbits[qi];
      end
      en_seen = DSM_EN_O;
    end
  end

  // Monitor: every strobe must carry the scoreboard head; each sample lasts OSR strobes.
  initial forever begin
    @(negedge MCLK_I);
    cyc++;
    if (mon_en) begin
      if (dsd_due) begin
        check_eq("dsd_bit", 32'(DSD_DATA_O), 32'(exp_bit));
        dsd_due = 1'b0;
      end
      if (DSM_EN_O) begin
        check_eq("sb_has_entry", 32'(exp_data_q.size() != 0), 1);
        if (exp_data_q.size() != 0) check_eq("dsm_data", DSM_DATA_O, exp_data_q[0]);
        check_eq("clr_in_run", 32'(DSM_CLR_O), 0);
        if (pulse_cnt != 0) check_eq("en_spacing", 32'(cyc - last_pulse), DIV);
        last_pulse = cyc;
        en_total++;
        exp_bit = QUANT_DATA_I;
        dsd_due = 1'b1;
        pulse_cnt++;
        if (pulse_cnt == OSR) begin
          pulse_cnt = 0;
          if (exp_data_q.size() != 0) void'(exp_data_q.pop_front());
        end
      end
    end
  end

  initial begin
    int n, en_mark, n_en;
    NRST_I      = 1'b0;
    EN_I        = 1'b0;
    PCM_VALID_I = 1'b0;
    PCM_DATA_I  = '0;
`ifdef DSM_CTRL_SILENCE_PATTERN_EN
    sil_exp = 8'h69;
`else
    sil_exp = 8'hAA;
`endif

    // Reset
    tick_n(5);
    check_eq("rst_ready", 32'(PCM_READY_O), 0);
    check_eq("rst_data", DSM_DATA_O, 0);
    check_eq("rst_en", 32'(DSM_EN_O), 0);
    check_eq("rst_clr", 32'(DSM_CLR_O), 1);
    check_eq("rst_dsd", 32'(DSD_DATA_O), 0);
    check_eq("rst_bck", 32'(DSD_BCK_O), 0);
    check_eq("rst_underrun", 32'(UNDERRUN_O), 0);
    check_eq("rst_state", 32'(STATE_O), 0);
    NRST_I = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick_n(1);
      check_eq("bck_phase", 32'(DSD_BCK_O), 32'((k % DIV) >= (DIV / 2)));
    end
    check_eq("idle_state", 32'(STATE_O), 0);
    check_eq("idle_ready", 32'(PCM_READY_O), 0);

    // Startup
    mon_en = 1'b1;
    EN_I   = 1'b1;
    send(32'h1234_5678);
    n = 0;
    while (STATE_O != 2'd2 && n < 50) begin
      tick_n(1);
      n++;
    end
    check_eq("run_entry_wait", 32'(n < 50), 1);
    check_eq("run_entry_bck", 32'(DSD_BCK_O), 0);
    check_eq("run_entry_data", DSM_DATA_O, 32'h1234_5678);
    check_eq("run_entry_clr", 32'(DSM_CLR_O), 0);
    n = 0;
    while (!DSM_EN_O && n < 20) begin
      tick_n(1);
      n++;
    end
    check_eq("first_en_latency", 32'(n), DIV - 1);

    // Streaming
    send(32'hCAFE_0001);
    send(32'h0BAD_F00D);
    send(32'h5555_AAAA);
    check_eq("stream_no_underrun", 32'(UNDERRUN_O), 0);

    // Bypass: offer a sample exactly in the consume cycle of the last held sample
    n = 0;
    while (!(exp_data_q.size() == 1 && DSM_EN_O && pulse_cnt == OSR - 1) && n < 400) begin
      tick_n(1);
      n++;
    end
    check_eq("bypass_slot_wait", 32'(n < 400), 1);
    check_eq("bypass_ready", 32'(PCM_READY_O), 1);
    PCM_DATA_I  = 32'hAAAA_0000;
    PCM_VALID_I = 1'b1;
    exp_data_q.push_back(32'hAAAA_0000);
    tick_n(1);
    PCM_VALID_I = 1'b0;
    check_eq("bypass_data", DSM_DATA_O, 32'hAAAA_0000);
    check_eq("bypass_no_underrun", 32'(UNDERRUN_O), 0);
    check_eq("bypass_hold_empty", 32'(PCM_READY_O), 1);

    // Underrun: stop feeding
    exp_data_q.push_back('0);
    n = 0;
    while (!UNDERRUN_O && n < 200) begin
      tick_n(1);
      n++;
    end
    check_eq("underrun_wait", 32'(n < 200), 1);
    check_eq("underrun_data", DSM_DATA_O, 0);
    check_eq("underrun_state", 32'(STATE_O), 2);
    en_mark = en_total;
    n = 0;
    while (STATE_O != 2'd3 && n < 200) begin
      tick_n(1);
      n++;
    end
    check_eq("mute_wait", 32'(n < 200), 1);
    check_eq("mute_after_pulses", 32'(en_total - en_mark), OSR);
    check_eq("mute_clr", 32'(DSM_CLR_O), 1);
    check_eq("mute_data", DSM_DATA_O, 0);
    check_eq("mute_underrun", 32'(UNDERRUN_O), 1);
    tick_n(1);
    check_eq("mute_to_prime", 32'(STATE_O), 1);
    check_eq("prime_clr", 32'(DSM_CLR_O), 1);
    tick_n(DIV - 1);
    for (int k = 0; k < 8; k++) begin
      check_eq("silence_bit", 32'(DSD_DATA_O), 32'(sil_exp[7-k]));
      if (k < 7) tick_n(DIV);
    end

    // Abort mid-sample
    send(32'h7777_1111);
    n = 0;
    while (!(STATE_O == 2'd2 && pulse_cnt == 3 && !DSM_EN_O) && n < 200) begin
      tick_n(1);
      n++;
    end
    check_eq("abort_slot_wait", 32'(n < 200), 1);
    check_eq("underrun_sticky", 32'(UNDERRUN_O), 1);
    EN_I = 1'b0;
    tick_n(1);
    check_eq("abort_state", 32'(STATE_O), 0);
    check_eq("abort_ready", 32'(PCM_READY_O), 0);
    check_eq("abort_underrun", 32'(UNDERRUN_O), 0);
    check_eq("abort_clr", 32'(DSM_CLR_O), 1);
    mon_en = 1'b0;
    n_en = 0;
    for (int k = 0; k < 40; k++) begin
      tick_n(1);
      if (DSM_EN_O) n_en++;
    end
    check_eq("abort_no_en", 32'(n_en), 0);

    // Asynchronous reset while active
    EN_I = 1'b1;
    tick_n(2);
    check_eq("reprime_state", 32'(STATE_O), 1);
    NRST_I = 1'b0;
    #1;
    check_eq("async_rst_state", 32'(STATE_O), 0);
    check_eq("async_rst_ready", 32'(PCM_READY_O), 0);
    check_eq("async_rst_clr", 32'(DSM_CLR_O), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
